// File: rtl/dff_mem_host.sv
// Initiator-side sequencer for the DFF RAM tile pin protocol: turns write/read burst
// commands into ce_n/lr_n strobe cycles and streams read bytes back on a valid/ready port.
module dff_mem_host #(
    parameter int unsigned RAM_BYTES = 16,
    parameter int unsigned ADDR_BITS = $clog2(RAM_BYTES)
) (
    input  logic                 clk,
    input  logic                 rst,

    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic                 cmd_write,
    input  logic [ADDR_BITS-1:0] cmd_addr,
    input  logic [ADDR_BITS-1:0] cmd_len,
    input  logic [7:0]           cmd_wdata,

    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [7:0]           rsp_data,
    output logic                 rsp_last,

    output logic                 busy,
    output logic                 rd_err,

    output logic [ADDR_BITS-1:0] mem_addr,
    output logic                 mem_ce_n,
    output logic                 mem_lr_n,
    output logic [7:0]           mem_wdata,
    output logic                 mem_wdata_oe,
    input  logic [7:0]           mem_rdata,
    input  logic                 mem_rdata_oe
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR,
        S_RD_REQ,
        S_RD_WAIT,
        S_RD_CAP,
        S_RSP
    } state_t;

    state_t               state_q, state_d;
    logic [ADDR_BITS-1:0] start_q, start_d;
    logic [ADDR_BITS-1:0] len_q, len_d;
    logic [7:0]           seed_q, seed_d;
    logic [ADDR_BITS-1:0] beat_q, beat_d;
    logic [ADDR_BITS-1:0] next_beat;
    logic                 last_beat;

    logic                 cmd_ready_q, cmd_ready_d;
    logic                 rsp_valid_q, rsp_valid_d;
    logic [7:0]           rsp_data_q, rsp_data_d;
    logic                 rsp_last_q, rsp_last_d;
    logic                 busy_q, busy_d;
    logic                 rd_err_q, rd_err_d;
    logic [ADDR_BITS-1:0] mem_addr_q, mem_addr_d;
    logic                 mem_ce_n_q, mem_ce_n_d;
    logic                 mem_lr_n_q, mem_lr_n_d;
    logic [7:0]           mem_wdata_q, mem_wdata_d;
    logic                 mem_wdata_oe_q, mem_wdata_oe_d;

    // Address wraps naturally because RAM_BYTES is a power of two.
    assign next_beat = beat_q + ADDR_BITS'(1);
    assign last_beat = (beat_q == len_q);

    always_comb begin
        state_d        = state_q;
        start_d        = start_q;
        len_d          = len_q;
        seed_d         = seed_q;
        beat_d         = beat_q;
        cmd_ready_d    = cmd_ready_q;
        rsp_valid_d    = rsp_valid_q;
        rsp_data_d     = rsp_data_q;
        rsp_last_d     = rsp_last_q;
        busy_d         = busy_q;
        rd_err_d       = rd_err_q;
        mem_addr_d     = mem_addr_q;
        mem_ce_n_d     = mem_ce_n_q;
        mem_lr_n_d     = mem_lr_n_q;
        mem_wdata_d    = mem_wdata_q;
        mem_wdata_oe_d = mem_wdata_oe_q;

        unique case (state_q)
            S_IDLE: begin
                cmd_ready_d = 1'b1;
                if (cmd_valid && cmd_ready_q) begin
                    start_d     = cmd_addr;
                    len_d       = cmd_len;
                    seed_d      = cmd_wdata;
                    beat_d      = '0;
                    busy_d      = 1'b1;
                    cmd_ready_d = 1'b0;
                    mem_addr_d  = cmd_addr;
                    // Strobes for beat 0 are loaded here so they are live in the first WR/RD_REQ cycle.
                    if (cmd_write) begin
                        state_d        = S_WR;
                        mem_lr_n_d     = 1'b0;
                        mem_wdata_d    = cmd_wdata;
                        mem_wdata_oe_d = 1'b1;
                    end else begin
                        state_d    = S_RD_REQ;
                        mem_ce_n_d = 1'b0;
                    end
                end
            end

            S_WR: begin
                if (last_beat) begin
                    state_d        = S_IDLE;
                    mem_lr_n_d     = 1'b1;
                    mem_wdata_oe_d = 1'b0;
                    busy_d         = 1'b0;
                    cmd_ready_d    = 1'b1;
                end else begin
                    beat_d      = next_beat;
                    mem_addr_d  = start_q + next_beat;
                    mem_wdata_d = seed_q + 8'(next_beat);
                end
            end

            S_RD_REQ: begin
                mem_ce_n_d = 1'b1;
                state_d    = S_RD_WAIT;
            end

            S_RD_WAIT: begin
                state_d = S_RD_CAP;
            end

            S_RD_CAP: begin
                rsp_data_d  = mem_rdata;
                rsp_valid_d = 1'b1;
                rsp_last_d  = last_beat;
                if (!mem_rdata_oe) begin
                    rd_err_d = 1'b1;
                end
                state_d = S_RSP;
            end

            S_RSP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    rsp_last_d  = 1'b0;
                    if (last_beat) begin
                        state_d     = S_IDLE;
                        busy_d      = 1'b0;
                        cmd_ready_d = 1'b1;
                    end else begin
                        beat_d     = next_beat;
                        mem_addr_d = start_q + next_beat;
                        mem_ce_n_d = 1'b0;
                        state_d    = S_RD_REQ;
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= S_IDLE;
            start_q        <= '0;
            len_q          <= '0;
            seed_q         <= '0;
            beat_q         <= '0;
            cmd_ready_q    <= 1'b0;
            rsp_valid_q    <= 1'b0;
            rsp_data_q     <= '0;
            rsp_last_q     <= 1'b0;
            busy_q         <= 1'b0;
            rd_err_q       <= 1'b0;
            mem_addr_q     <= '0;
            mem_ce_n_q     <= 1'b1;
            mem_lr_n_q     <= 1'b1;
            mem_wdata_q    <= '0;
            mem_wdata_oe_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            start_q        <= start_d;
            len_q          <= len_d;
            seed_q         <= seed_d;
            beat_q         <= beat_d;
            cmd_ready_q    <= cmd_ready_d;
            rsp_valid_q    <= rsp_valid_d;
            rsp_data_q     <= rsp_data_d;
            rsp_last_q     <= rsp_last_d;
            busy_q         <= busy_d;
            rd_err_q       <= rd_err_d;
            mem_addr_q     <= mem_addr_d;
            mem_ce_n_q     <= mem_ce_n_d;
            mem_lr_n_q     <= mem_lr_n_d;
            mem_wdata_q    <= mem_wdata_d;
            mem_wdata_oe_q <= mem_wdata_oe_d;
        end
    end

    assign cmd_ready    = cmd_ready_q;
    assign rsp_valid    = rsp_valid_q;
    assign rsp_data     = rsp_data_q;
    assign rsp_last     = rsp_last_q;
    assign busy         = busy_q;
    assign rd_err       = rd_err_q;
    assign mem_addr     = mem_addr_q;
    assign mem_ce_n     = mem_ce_n_q;
    assign mem_lr_n     = mem_lr_n_q;
    assign mem_wdata    = mem_wdata_q;
    assign mem_wdata_oe = mem_wdata_oe_q;

endmodule

// File: tb/tb_dff_mem_host.sv
// Bench for dff_mem_host: a pin-level RAM tile model plus a byte-array reference of what
// the RAM should hold, driven by directed steps followed by random bursts.
module tb_dff_mem_host;

    localparam int unsigned RAM_BYTES = 16;
    localparam int unsigned ADDR_BITS = 4;

    logic                 clk;
    logic                 rst;
    logic                 cmd_valid;
    logic                 cmd_ready;
    logic                 cmd_write;
    logic [ADDR_BITS-1:0] cmd_addr;
    logic [ADDR_BITS-1:0] cmd_len;
    logic [7:0]           cmd_wdata;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [7:0]           rsp_data;
    logic                 rsp_last;
    logic                 busy;
    logic                 rd_err;
    logic [ADDR_BITS-1:0] mem_addr;
    logic                 mem_ce_n;
    logic                 mem_lr_n;
    logic [7:0]           mem_wdata;
    logic                 mem_wdata_oe;
    logic [7:0]           mem_rdata;
    logic                 mem_rdata_oe;

    int unsigned vectors = 0;
    int unsigned miscompares = 0;
    int unsigned cyc = 0;

    logic [7:0] ram [RAM_BYTES];
    logic [7:0] ref_mem [RAM_BYTES];
    logic [7:0] ram_q = '0;
    logic       ram_oe = 1'b0;
    logic       bad_oe = 1'b0;

    dff_mem_host #(.RAM_BYTES(RAM_BYTES)) dut (
        .clk          (clk),
        .rst          (rst),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_write    (cmd_write),
        .cmd_addr     (cmd_addr),
        .cmd_len      (cmd_len),
        .cmd_wdata    (cmd_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_data     (rsp_data),
        .rsp_last     (rsp_last),
        .busy         (busy),
        .rd_err       (rd_err),
        .mem_addr     (mem_addr),
        .mem_ce_n     (mem_ce_n),
        .mem_lr_n     (mem_lr_n),
        .mem_wdata    (mem_wdata),
        .mem_wdata_oe (mem_wdata_oe),
        .mem_rdata    (mem_rdata),
        .mem_rdata_oe (mem_rdata_oe)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // RAM tile: stores on lr_n low, registers read data on ce_n low; not affected by rst.
    always @(posedge clk) begin
        if (!mem_lr_n) ram[mem_addr] <= mem_wdata;
        if (!mem_ce_n) begin
            ram_q  <= ram[mem_addr];
            ram_oe <= !bad_oe;
        end
        cyc <= cyc + 1;
    end
    assign mem_rdata    = ram_q;
    assign mem_rdata_oe = ram_oe;

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        check("strobe_exclusive", {31'd0, !mem_ce_n && !mem_lr_n}, 0);
        check("wdata_oe_only_writing", {31'd0, mem_wdata_oe}, {31'd0, !mem_lr_n});
    endtask

    task automatic send_cmd(input logic w, input int a, input int l, input int s,
                            output int unsigned acc);
        int n = 0;
        while (!cmd_ready && n < 50) begin
            tick();
            n++;
        end
        check("cmd_ready_wait", {31'd0, cmd_ready}, 1);
        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_addr  = ADDR_BITS'(a);
        cmd_len   = ADDR_BITS'(l);
        cmd_wdata = 8'(s);
        tick();
        acc = cyc;
        cmd_valid = 1'b0;
        check("cmd_ready_drop", {31'd0, cmd_ready}, 0);
        check("busy_on_accept", {31'd0, busy}, 1);
    endtask

    task automatic do_write(input int a, input int l, input int s);
        int unsigned acc;
        send_cmd(1'b1, a, l, s, acc);
        for (int k = 0; k <= l; k++) begin
            check("wr_lr_n", {31'd0, mem_lr_n}, 0);
            check("wr_ce_n", {31'd0, mem_ce_n}, 1);
            check("wr_addr", {28'd0, mem_addr}, (a + k) % RAM_BYTES);
            check("wr_data", {24'd0, mem_wdata}, (s + k) % 256);
            check("wr_busy", {31'd0, busy}, 1);
            ref_mem[(a + k) % RAM_BYTES] = 8'((s + k) % 256);
            tick();
        end
        check("wr_end_lr_n", {31'd0, mem_lr_n}, 1);
        check("wr_end_busy", {31'd0, busy}, 0);
        check("wr_end_ready", {31'd0, cmd_ready}, 1);
    endtask

    task automatic do_read(input int a, input int l, input int smin, input int smax,
                           input bit hold, input bit noise);
        int unsigned t0;
        int n;
        int stall;
        logic [7:0] e;
        if (hold) rsp_ready = 1'b1;
        send_cmd(1'b0, a, l, 0, t0);
        for (int k = 0; k <= l; k++) begin
            n = 0;
            while (!rsp_valid && n < 20) begin
                tick();
                n++;
            end
            check("rd_valid", {31'd0, rsp_valid}, 1);
            check("rd_beat_latency", cyc - t0, 3);
            e = ref_mem[(a + k) % RAM_BYTES];
            stall = $urandom_range(smax, smin);
            if (stall > 0) begin
                rsp_ready = 1'b0;
                if (noise) begin
                    cmd_valid = 1'b1;
                    cmd_write = 1'b1;
                end
                for (int i = 0; i < stall; i++) begin
                    tick();
                    check("stall_valid", {31'd0, rsp_valid}, 1);
                    check("stall_data", {24'd0, rsp_data}, {24'd0, e});
                    check("stall_ce_n", {31'd0, mem_ce_n}, 1);
                    check("stall_cmd_ready", {31'd0, cmd_ready}, 0);
                end
                cmd_valid = 1'b0;
            end
            check("rd_data", {24'd0, rsp_data}, {24'd0, e});
            check("rd_last", {31'd0, rsp_last}, (k == l) ? 1 : 0);
            rsp_ready = 1'b1;
            tick();
            t0 = cyc;
            if (!hold) rsp_ready = 1'b0;
            check("rd_valid_drop", {31'd0, rsp_valid}, 0);
        end
        rsp_ready = 1'b0;
        check("rd_end_busy", {31'd0, busy}, 0);
        check("rd_end_ready", {31'd0, cmd_ready}, 1);
    endtask

    initial begin
        int unsigned acc;
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_len   = '0;
        cmd_wdata = '0;
        rsp_ready = 1'b0;
        repeat (3) tick();
        check("rst_cmd_ready", {31'd0, cmd_ready}, 0);
        check("rst_rsp_valid", {31'd0, rsp_valid}, 0);
        check("rst_rsp_data", {24'd0, rsp_data}, 0);
        check("rst_rsp_last", {31'd0, rsp_last}, 0);
        check("rst_busy", {31'd0, busy}, 0);
        check("rst_rd_err", {31'd0, rd_err}, 0);
        check("rst_mem_addr", {28'd0, mem_addr}, 0);
        check("rst_ce_n", {31'd0, mem_ce_n}, 1);
        check("rst_lr_n", {31'd0, mem_lr_n}, 1);
        check("rst_wdata", {24'd0, mem_wdata}, 0);
        check("rst_wdata_oe", {31'd0, mem_wdata_oe}, 0);
        rst = 1'b0;

        // Single-beat write, then a burst that wraps past the top address.
        do_write(3, 0, 'hA5);
        do_write(14, 3, 'h10);
        do_read(14, 3, 0, 0, 1'b1, 1'b0);
        check("rd_err_clean", {31'd0, rd_err}, 0);

        // Full-RAM burst: every byte written once with a distinct value, then read back.
        do_write(5, RAM_BYTES - 1, 'hC0);
        do_read(0, RAM_BYTES - 1, 0, 0, 1'b0, 1'b0);

        // Backpressure with a stray command offered while stalled.
        do_read(9, 1, 5, 5, 1'b0, 1'b1);
        tick();
        check("no_queued_cmd_busy", {31'd0, busy}, 0);
        check("no_queued_cmd_lr_n", {31'd0, mem_lr_n}, 1);

        // Sticky read error.
        bad_oe = 1'b1;
        do_read(2, 1, 0, 0, 1'b0, 1'b0);
        check("rd_err_set", {31'd0, rd_err}, 1);
        bad_oe = 1'b0;
        do_read(7, 2, 0, 1, 1'b0, 1'b0);
        check("rd_err_sticky", {31'd0, rd_err}, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rd_err_cleared", {31'd0, rd_err}, 0);

        // Reset during beat 2 of an 8-beat write: beats 0..2 land, the rest are dropped.
        send_cmd(1'b1, 8, 7, 'h80, acc);
        for (int k = 0; k < 3; k++) begin
            check("abort_wr_addr", {28'd0, mem_addr}, 8 + k);
            ref_mem[8 + k] = 8'('h80 + k);
            if (k == 2) rst = 1'b1;
            tick();
        end
        rst = 1'b0;
        check("abort_lr_n", {31'd0, mem_lr_n}, 1);
        check("abort_wdata_oe", {31'd0, mem_wdata_oe}, 0);
        check("abort_busy", {31'd0, busy}, 0);
        check("abort_ce_n", {31'd0, mem_ce_n}, 1);
        do_read(8, 7, 0, 2, 1'b0, 1'b0);

        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(1, 0) == 1)
                do_write($urandom_range(RAM_BYTES - 1, 0), $urandom_range(5, 0), $urandom_range(255, 0));
            else
                do_read($urandom_range(RAM_BYTES - 1, 0), $urandom_range(5, 0), 0, 3, 1'b0, 1'b0);
        end
        do_read(0, RAM_BYTES - 1, 0, 0, 1'b1, 1'b0);
        check("final_rd_err", {31'd0, rd_err}, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/dff_mem_host.md
Name: dff_mem_host

Overview:
- Initiator-side sequencer for the 8-bit DFF RAM macro's pin protocol: active-low chip enable, active-low load/write strobe, address bus, shared 8-bit data.
- Accepts burst commands on a valid/ready port.
- Converts them into correctly timed RAM strobe cycles.
- Returns read bytes on a valid/ready response stream.
- Sits between on-chip control logic (or a test harness) and the RAM tile's ui/uio pins.

Parameters:
- RAM_BYTES, 16, bytes in the target RAM; must be a power of two, 2..128.
- ADDR_BITS, $clog2(RAM_BYTES), address width (derived; not overridden).

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  synchronous reset, active-high.
- cmd_valid  input  1  command offered.
- cmd_ready  output  1  command accepted when cmd_valid & cmd_ready.
- cmd_write  input  1  1 = write burst, 0 = read burst.
- cmd_addr  input  ADDR_BITS  start address.
- cmd_len  input  ADDR_BITS  beats minus one (0 = 1 beat).
- cmd_wdata  input  8  write seed; beat k writes cmd_wdata+k (mod 256).
- rsp_valid  output  1  read byte available.
- rsp_ready  input  1  consumer accepts byte.
- rsp_data  output  8  read byte.
- rsp_last  output  1  final beat of the read burst.
- busy  output  1  high whenever the FSM is not in IDLE.
- rd_err  output  1  sticky; set when mem_rdata_oe=0 at a capture edge.
- mem_addr  output  ADDR_BITS  RAM address.
- mem_ce_n  output  1  RAM read enable, active low.
- mem_lr_n  output  1  RAM write strobe, active low.
- mem_wdata  output  8  data to the RAM.
- mem_wdata_oe  output  1  1 while mem_wdata is being driven.
- mem_rdata  input  8  RAM registered read data.
- mem_rdata_oe  input  1  RAM output-enable indication (any bit of its oe bus).

Behaviour:
- All outputs are registered.
- Reset values: cmd_ready=0, rsp_valid=0, rsp_data=0, rsp_last=0, busy=0, rd_err=0, mem_addr=0, mem_ce_n=1, mem_lr_n=1, mem_wdata=0, mem_wdata_oe=0.
- FSM states are IDLE, WR, RD_REQ, RD_WAIT, RD_CAP, RSP.
- IDLE:
  - cmd_ready=1.
  - On handshake: latch addr/len/seed, clear beat counter k, set busy.
  - Go to WR if cmd_write, else RD_REQ.
  - cmd_ready drops the cycle after acceptance.
- WR (one beat per cycle):
  - Drive mem_lr_n=0, mem_ce_n=1, mem_addr=start+k, mem_wdata=seed+k, mem_wdata_oe=1.
  - The RAM stores the byte at the following edge.
  - After beat k=len, deassert lr_n/oe and return to IDLE. A write burst occupies len+1 cycles.
- RD_REQ: drive mem_ce_n=0 for exactly one cycle with mem_addr=start+k.
- RD_WAIT: mem_ce_n=1. The RAM's registered data is valid on mem_rdata during this cycle.
- RD_CAP:
  - Sample mem_rdata into rsp_data and set rsp_valid.
  - Set rsp_last if k=len.
  - If mem_rdata_oe=0, set rd_err (cleared only by rst).
- RSP: hold rsp_valid/rsp_data/rsp_last stable until rsp_ready.
  - On handshake with k<len: k++, go to RD_REQ.
  - On handshake with k=len: go to IDLE.
- Read latency: first rsp_valid appears 3 cycles after command acceptance. Each subsequent beat takes at least 3 cycles plus any backpressure.
- Address arithmetic is modulo RAM_BYTES: a burst crossing the top wraps to 0. A burst of RAM_BYTES beats touches every byte exactly once.
- Invariant: mem_ce_n and mem_lr_n are never both 0 in the same cycle.
- Invariant: mem_wdata_oe=1 only in WR.
- cmd_valid during a burst is ignored; it is not queued.
- rsp_ready with rsp_valid=0 has no effect.
- rst mid-burst returns all outputs to reset values on the next edge. The remaining beats are dropped. A partially written burst leaves already-written bytes in the RAM.

Test Plan:
- Reset, then write addr=3 len=0 wdata=0xA5 -> exactly one cycle with mem_lr_n=0, mem_addr=3, mem_wdata=0xA5; busy high 1 cycle; cmd_ready back at 1.
- Write addr=14 len=3 seed=0x10 (RAM_BYTES=16) -> addresses 14,15,0,1 with data 0x10,0x11,0x12,0x13 on 4 consecutive cycles; mem_ce_n stays 1.
- Then read addr=14 len=3 with rsp_ready=1 -> rsp_data 0x10,0x11,0x12,0x13; first rsp_valid 3 cycles after accept; rsp_last only on 0x13; rd_err=0.
- Read len=1 with rsp_ready held 0 for 5 cycles -> rsp_valid/rsp_data stable, no mem_ce_n pulse until handshake; second byte follows correctly.
- Read with RAM model forcing mem_rdata_oe=0 -> rd_err=1 and stays set through later good bursts until rst.
- Assert rst during beat 2 of an 8-beat write -> next cycle mem_lr_n=1, mem_wdata_oe=0, busy=0; only beats 0..1 (and beat 2 if its edge preceded reset) present in the RAM; new command accepted normally.
